// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared constants, state encoding and helpers for multdiv
// MULTDIV_DIV_EN (defined elsewhere) compiles in the divider; these definitions serve both builds.
package multdiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITERS = 32;
  localparam logic [MD_WIDTH-1:0] MD_INT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } md_state_e;

  function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] v);
    return v[MD_WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/cla32.sv
// rtl/cla32.sv - 32-bit adder with carry in/out, shared by the Booth and restoring-divide steps
module cla32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};

endmodule

// File: rtl/multdiv_count.sv
// rtl/multdiv_count.sv - 6-bit iteration counter with clear, enable and done flag
module multdiv_count
  import multdiv_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  logic [5:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 6'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == 6'(MD_ITERS));

endmodule

// File: rtl/multdiv.sv
// rtl/multdiv.sv - iterative signed 32-bit Booth multiply / restoring divide unit
// Divider datapath and DIV/FIX states are present only when MULTDIV_DIV_EN is defined.
module multdiv
  import multdiv_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic [MD_WIDTH-1:0] data_operandA,
  input  logic [MD_WIDTH-1:0] data_operandB,
  input  logic                ctrl_MULT,
  input  logic                ctrl_DIV,
  output logic [MD_WIDTH-1:0] data_result,
  output logic                data_exception,
  output logic                data_resultRDY
);

  md_state_e           state_q, state_d;
  logic [MD_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d, res_q, res_d;
  logic                qm1_q, qm1_d, exc_q, exc_d;
`ifdef MULTDIV_DIV_EN
  logic                sign_q, sign_d, dz_q, dz_d, dovf_q, dovf_d;
`else
  logic                pend_q, pend_d;
`endif
  logic                cnt_clr, cnt_en, cnt_done;
  logic [MD_WIDTH-1:0] add_a, add_b, add_sum;
  logic                add_cin, add_cout, add_sign;

  multdiv_count u_count (
    .clock  (clock),
    .reset_n(reset_n),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .done_o (cnt_done)
  );

  cla32 u_add (
    .a_i   (add_a),
    .b_i   (add_b),
    .cin_i (add_cin),
    .sum_o (add_sum),
    .cout_o(add_cout)
  );

  always_comb begin
    add_a   = hi_q;
    add_b   = '0;
    add_cin = 1'b0;
`ifdef MULTDIV_DIV_EN
    if (state_q == DIV) begin
      add_a   = {hi_q[MD_WIDTH-2:0], lo_q[MD_WIDTH-1]};
      add_b   = ~m_q;
      add_cin = 1'b1;
    end else
`endif
    if (lo_q[0] != qm1_q) begin
      add_b   = lo_q[0] ? ~m_q : m_q;
      add_cin = lo_q[0];
    end
  end

  // True 33rd bit of the Booth partial sum; keeps the shift right when the add overflows 32 bits.
  assign add_sign = add_a[MD_WIDTH-1] ^ add_b[MD_WIDTH-1] ^ add_cout;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    res_d   = res_q;
    exc_d   = exc_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
`ifdef MULTDIV_DIV_EN
    sign_d  = sign_q;
    dz_d    = dz_q;
    dovf_d  = dovf_q;
`else
    pend_d  = 1'b0;
`endif
    case (state_q)
      MUL: begin
        if (cnt_done) begin
          state_d = DONE;
          res_d   = lo_q;
          exc_d   = (hi_q != {MD_WIDTH{lo_q[MD_WIDTH-1]}});
        end else begin
          cnt_en = 1'b1;
          {hi_d, lo_d, qm1_d} = {add_sign, add_sum, lo_q};
        end
      end
`ifdef MULTDIV_DIV_EN
      DIV: begin
        if (cnt_done) begin
          state_d = FIX;
        end else begin
          cnt_en = 1'b1;
          hi_d   = add_cout ? add_sum : add_a;
          lo_d   = {lo_q[MD_WIDTH-2:0], add_cout};
        end
      end
      FIX: begin
        state_d = DONE;
        res_d   = dz_q ? '0 : (sign_q ? -lo_q : lo_q);
        exc_d   = dz_q | dovf_q;
      end
`endif
      DONE: state_d = IDLE;
      default: begin
`ifndef MULTDIV_DIV_EN
        if (pend_q && !ctrl_MULT && !ctrl_DIV) begin
          state_d = DONE;
          res_d   = '0;
          exc_d   = 1'b1;
        end
`endif
      end
    endcase

    // A start pulse overrides whatever the current state was doing.
    if (ctrl_MULT) begin
      state_d = MUL;
      cnt_clr = 1'b1;
      hi_d    = '0;
      lo_d    = data_operandB;
      qm1_d   = 1'b0;
      m_d     = data_operandA;
    end else if (ctrl_DIV) begin
`ifdef MULTDIV_DIV_EN
      state_d = DIV;
      cnt_clr = 1'b1;
      hi_d    = '0;
      lo_d    = md_abs(data_operandA);
      m_d     = md_abs(data_operandB);
      sign_d  = data_operandA[MD_WIDTH-1] ^ data_operandB[MD_WIDTH-1];
      dz_d    = (data_operandB == '0);
      dovf_d  = (data_operandA == MD_INT_MIN) && (data_operandB == '1);
`else
      state_d = IDLE;
      pend_d  = 1'b1;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
`ifdef MULTDIV_DIV_EN
      sign_q  <= 1'b0;
      dz_q    <= 1'b0;
      dovf_q  <= 1'b0;
`else
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
`ifdef MULTDIV_DIV_EN
      sign_q  <= sign_d;
      dz_q    <= dz_d;
      dovf_q  <= dovf_d;
`else
      pend_q  <= pend_d;
`endif
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);

endmodule

// File: doc/multdiv.md
# multdiv

Sequential multiply/divide unit next to the combinational ALU in the execute stage. It computes the signed 32-bit product or truncating quotient of two operands using iterative shift-add/subtract. A one-cycle start pulse begins the operation and a one-cycle ready pulse ends it. The pipeline stalls while the unit is busy.

## Interface
Parameters:
- none (iteration count and widths are fixed constants in the package)

Ports:
- clock  input  1  rising-edge clock; the only clock
- reset_n  input  1  asynchronous, active-low reset
- data_operandA  input  32  multiplicand / dividend, two's complement
- data_operandB  input  32  multiplier / divisor, two's complement
- ctrl_MULT  input  1  start multiply, one-cycle pulse
- ctrl_DIV  input  1  start divide, one-cycle pulse
- data_result  output  32  low 32 bits of product, or quotient
- data_exception  output  1  overflow or divide fault, valid with data_resultRDY
- data_resultRDY  output  1  one-cycle result-valid pulse

## Operation
- Operands are latched at the edge where ctrl_MULT or ctrl_DIV is sampled high. They are not re-read after that edge.
- States: IDLE, MUL, DIV, FIX, DONE.
  - IDLE -> MUL on ctrl_MULT.
  - IDLE -> DIV on ctrl_DIV.
  - MUL -> DONE after 32 iterations.
  - DIV -> FIX after 32 iterations.
  - FIX -> DONE.
  - DONE -> IDLE.
- Multiply uses radix-2 Booth over a 65-bit {A, Q, q-1} register. Each iteration does one add/sub of the multiplicand into the upper 32 bits, then an arithmetic right shift by 1.
- data_exception for multiply is 1 when product[63:32] is not the sign extension of product[31].
- Divide uses restoring division on operand magnitudes, with 32 iterations. FIX applies the quotient sign (signA XOR signB); the remainder is discarded.
- Division by zero gives data_result = 0 and data_exception = 1.
- 0x80000000 / -1 gives data_result = 0x80000000 and data_exception = 1.
- Simultaneous ctrl_MULT and ctrl_DIV: multiply wins.
- A start pulse in any non-IDLE state aborts the current operation and restarts with the new operands and operation. No data_resultRDY is issued for the aborted operation.
- data_result and data_exception hold their last values until the next DONE.
- Iteration counter: 6 bits, cleared on start. It increments once per MUL/DIV cycle and leaves the state when it reaches 32.

## Timing
- Reset values:
  - data_result = 0
  - data_exception = 0
  - data_resultRDY = 0
  - state = IDLE
  - counter = 0
- Reset asserted mid-operation returns the unit to IDLE immediately. No data_resultRDY is issued.
- Call the start edge edge 0. data_resultRDY is high in the cycle after:
  - edge 33 for multiply
  - edge 34 for divide (33 + FIX)
- data_resultRDY is high for exactly one cycle. data_result and data_exception are registered and valid in that same cycle.
- Divide by zero still takes the full 34 cycles, so latency is data-independent.
- A start sampled in the DONE cycle is accepted: the unit moves directly to MUL/DIV and data_resultRDY still pulses for the finishing result.

## Configuration
- MULTDIV_DIV_EN defined: divider datapath, DIV and FIX states are compiled in, with behaviour as above.
- MULTDIV_DIV_EN undefined:
  - ctrl_DIV goes IDLE -> DONE at the next edge.
  - data_resultRDY is high in the cycle after edge 1, with data_result = 0 and data_exception = 1.
  - Multiply is unchanged.

## Structure
- multdiv_pkg holds:
  - the state enum (IDLE, MUL, DIV, FIX, DONE)
  - MD_WIDTH = 32
  - MD_ITERS = 32
  - the MD_INT_MIN constant
- The add/subtract step reuses the existing cla32 adder, shared between Booth and the divider.
- One sub-module is natural: multdiv_count, a 6-bit iteration counter with clear, enable and a done flag.

## Test plan
- A = 7, B = -6, ctrl_MULT pulse -> data_resultRDY one cycle, 33 cycles after start; data_result = 0xFFFFFFD6 (-42); exception = 0.
- A = 0x40000000, B = 4, multiply -> data_result = 0x00000000, exception = 1.
- A = -43, B = 5, ctrl_DIV -> data_resultRDY 34 cycles after start; data_result = -8 (0xFFFFFFF8); exception = 0. Repeat with B = 0 -> result 0, exception 1, same latency.
- A = 0x80000000, B = -1, divide -> result 0x80000000, exception 1.
- Multiply started, ctrl_DIV with A = 100, B = 7 pulsed at cycle 10 -> no RDY for the multiply; RDY at 34 cycles after the restart with result 14.
- reset_n low at cycle 20 of a divide -> outputs 0 immediately, no RDY. Then simultaneous ctrl_MULT and ctrl_DIV with A = 3, B = 5 -> product 15 at 33 cycles.
